// File: rtl/pll_phase_scan_pkg.sv
// Shared types and constants for the PLL phase scan sequencer.
package pll_phase_scan_pkg;

    localparam int PHASE_W          = 8;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_LOCK_TIMEOUT = 65535;

    // Record count value reserved to flag a point whose PLL never locked.
    localparam logic [DEF_CNT_W-1:0] TIMEOUT_MARK = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_WAITLOCK,
        S_SETTLE,
        S_DWELL,
        S_REPORT,
        S_ADVANCE
    } state_t;

endpackage

// File: rtl/pll_phase_scan_hit_window_counter.sv
// Counts hit strobes over a fixed-length window; the count saturates one below
// all-ones so it can never alias the lock-timeout marker.
module hit_window_counter #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_hit,
    input  logic [LEN_W-1:0] i_length,
    output logic             o_window_done,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] SAT = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [LEN_W-1:0] r_tick;
    logic [CNT_W-1:0] r_count;
    logic [LEN_W-1:0] w_last;

    // A zero length behaves as a one-cycle window.
    assign w_last        = (i_length == '0) ? '0 : i_length - LEN_W'(1);
    assign o_window_done = i_enable && (r_tick == w_last);
    assign o_count       = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_tick  <= '0;
            r_count <= '0;
        end else if (i_enable) begin
            r_tick <= r_tick + LEN_W'(1);
            if (i_hit && (r_count != SAT))
                r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pll_phase_scan.sv
// Sweeps the PLL output phase over a range, measuring hit coincidences per
// phase point and handing each (phase, count) record out over valid/ready.
module pll_phase_scan
    import pll_phase_scan_pkg::*;
#(
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PHASE_W-1:0] i_phase_start,
    input  logic [PHASE_W-1:0] i_phase_stop,
    input  logic [PHASE_W-1:0] i_phase_step,
    input  logic [15:0]        i_settle_ticks,
    input  logic [31:0]        i_dwell_ticks,
    input  logic               i_hit,
    input  logic               i_pll_locked,
    output logic [PHASE_W-1:0] o_pll_clk_phase,
    output logic               o_updatepll,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [PHASE_W-1:0] o_res_phase,
    output logic [CNT_W-1:0]   o_res_count,
    output logic               o_lock_err
);

    localparam logic [31:0] LT_LAST = 32'(LOCK_TIMEOUT - 1);

    state_t             r_state, w_next;
    logic [PHASE_W-1:0] r_phase, r_stop, r_step;
    logic [15:0]        r_settle;
    logic [31:0]        r_dwell;
    logic [31:0]        r_timer;
    logic               r_lock_err;
    logic               r_pt_timeout;

    logic [PHASE_W:0]   w_next9;
    logic               w_adv_end;
    logic [15:0]        w_settle_last;
    logic               w_settle_done;
    logic               w_lock_ok;
    logic               w_lock_to;
    logic               w_abort;
    logic               w_win_done;
    logic [CNT_W-1:0]   w_count;

    // Widened add so a step past 255 ends the scan instead of wrapping.
    assign w_next9       = {1'b0, r_phase} + {1'b0, r_step};
    assign w_adv_end     = w_next9[PHASE_W] || (w_next9 > {1'b0, r_stop});
    assign w_settle_last = (r_settle == 16'd0) ? 16'd0 : r_settle - 16'd1;
    assign w_settle_done = (r_timer == {16'd0, w_settle_last});
    // The PLL drops lock right after an update, so the first cycle is ignored.
    assign w_lock_ok     = (r_timer != 32'd0) && i_pll_locked;
    assign w_lock_to     = (r_timer >= LT_LAST);
    assign w_abort       = i_abort && (r_state != S_IDLE);

    hit_window_counter #(
        .CNT_W (CNT_W),
        .LEN_W (32)
    ) u_win (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (r_state == S_UPDATE),
        .i_enable      (r_state == S_DWELL),
        .i_hit         (i_hit),
        .i_length      (r_dwell),
        .o_window_done (w_win_done),
        .o_count       (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_updatepll = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_UPDATE;
            S_UPDATE: begin
                o_updatepll = 1'b1;
                w_next      = S_WAITLOCK;
            end
            S_WAITLOCK: begin
                if (w_lock_ok)      w_next = S_SETTLE;
                else if (w_lock_to) w_next = S_REPORT;
            end
            S_SETTLE:   if (w_settle_done) w_next = S_DWELL;
            S_DWELL:    if (w_win_done) w_next = S_REPORT;
            S_REPORT:   if (i_res_ready) w_next = S_ADVANCE;
            S_ADVANCE: begin
                if (w_adv_end) begin
                    w_next = S_IDLE;
                    o_done = 1'b1;
                end else begin
                    w_next = S_UPDATE;
                end
            end
            default:    w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            o_done = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase      <= '0;
            r_stop       <= '0;
            r_step       <= '0;
            r_settle     <= '0;
            r_dwell      <= '0;
            r_timer      <= '0;
            r_lock_err   <= 1'b0;
            r_pt_timeout <= 1'b0;
        end else if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_phase    <= i_phase_start;
                        r_stop     <= i_phase_stop;
                        r_step     <= (i_phase_step == '0) ? PHASE_W'(1) : i_phase_step;
                        r_settle   <= i_settle_ticks;
                        r_dwell    <= i_dwell_ticks;
                        r_lock_err <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    r_timer      <= '0;
                    r_pt_timeout <= 1'b0;
                end
                S_WAITLOCK: begin
                    if (w_lock_ok) begin
                        r_timer <= '0;
                    end else if (w_lock_to) begin
                        r_pt_timeout <= 1'b1;
                        r_lock_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_SETTLE:  r_timer <= r_timer + 32'd1;
                S_ADVANCE: if (!w_adv_end) r_phase <= w_next9[PHASE_W-1:0];
                default: ;
            endcase
        end
    end

    assign o_pll_clk_phase = r_phase;
    assign o_busy          = (r_state != S_IDLE);
    assign o_res_valid     = (r_state == S_REPORT);
    assign o_res_phase     = o_res_valid ? r_phase : '0;
    assign o_res_count     = !o_res_valid ? '0 : (r_pt_timeout ? {CNT_W{1'b1}} : w_count);
    assign o_lock_err      = r_lock_err;

endmodule
